// File: rtl/newton_pkg.sv
// newton_pkg: shared types and constants for the Newton job sequencer.
//   state_t      - sequencer state encoding (frame assembler uses IDLE/COLLECT/CHECK,
//                  top FSM uses IDLE/LAUNCH/WAIT/RESP_S/RESP_D)
//   STATUS_*     - response status byte codes
//   HDR_DEFAULT  - default frame header byte
//   FRAME_LEN    - bytes per command frame (HDR, A, B, C, X0, CK)
package newton_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP_S,
    ST_RESP_D
  } state_t;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_FAIL    = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;
  localparam logic [7:0] STATUS_CKSUM   = 8'h03;

  localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN   = 6;
  // Payload bytes between header and checksum: A, B, C, X0.
  localparam int unsigned DATA_BYTES  = FRAME_LEN - 2;

endpackage

// File: rtl/newton_frame_rx.sv
// newton_frame_rx: assembles one command frame from the RX byte stream.
//   clk, reset         clock, synchronous active-high reset
//   enable             byte intake allowed (top FSM idle)
//   rx_data, rx_valid  UART RX byte stream
//   receiving          high in IDLE/COLLECT, i.e. a byte offered now would be consumed
//   active             high outside IDLE (frame in progress)
//   frame_ok/bad       one-cycle pulse in CHECK: checksum matched / mismatched
//   a, b, c, x0        low W bits of the payload bytes of the last frame
module newton_frame_rx
  import newton_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter logic [7:0]  HDR = HDR_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         receiving,
  output logic         active,
  output logic         frame_ok,
  output logic         frame_bad,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] x0
);

  state_t       state_q, state_d;
  logic [2:0]   idx_q;
  logic [7:0]   csum_q;
  logic [7:0]   ck_q;
  logic [W-1:0] data_q [DATA_BYTES];
  logic         take;
  logic         last_byte;

  assign take      = enable && rx_valid;
  // idx counts payload bytes; once all are in, the next byte is the checksum.
  assign last_byte = (idx_q == 3'(DATA_BYTES));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (take && rx_data == HDR) state_d = ST_COLLECT;
      ST_COLLECT: if (take && last_byte)      state_d = ST_CHECK;
      ST_CHECK:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      ck_q    <= '0;
      for (int unsigned i = 0; i < DATA_BYTES; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (take && rx_data == HDR) begin
            idx_q  <= '0;
            csum_q <= HDR;
          end
        end
        ST_COLLECT: begin
          if (take) begin
            if (!last_byte) begin
              data_q[idx_q[1:0]] <= rx_data[W-1:0];
              csum_q             <= csum_q ^ rx_data;
              idx_q              <= idx_q + 3'd1;
            end else begin
              ck_q <= rx_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign receiving = (state_q != ST_CHECK);
  assign active    = (state_q != ST_IDLE);
  assign frame_ok  = (state_q == ST_CHECK) && (csum_q == ck_q);
  assign frame_bad = (state_q == ST_CHECK) && (csum_q != ck_q);

  assign a  = data_q[0];
  assign b  = data_q[1];
  assign c  = data_q[2];
  assign x0 = data_q[3];

endmodule

// File: rtl/newton_job_sequencer.sv
// newton_job_sequencer: runs one Newton solver job per UART command frame and
// returns a 2-byte STATUS/RESULT response.
//   clk, reset                 clock, synchronous active-high reset
//   rx_data, rx_valid          UART RX byte stream
//   tx_data, tx_valid, tx_ready UART TX handshake (byte held until accepted)
//   slv_a/b/c/x0               signed solver operands, stable between launches
//   slv_start, slv_abort       one-cycle solver control pulses
//   slv_done, slv_failed, slv_x solver completion and result
//   busy                       high whenever a job or frame is in progress
//   drop_cnt                   saturating count of RX bytes dropped while not receiving
module newton_job_sequencer
  import newton_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  HDR     = HDR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic signed [W-1:0] slv_a,
  output logic signed [W-1:0] slv_b,
  output logic signed [W-1:0] slv_c,
  output logic signed [W-1:0] slv_x0,
  output logic                slv_start,
  output logic                slv_abort,
  input  logic                slv_done,
  input  logic                slv_failed,
  input  logic signed [W-1:0] slv_x,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned    TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [7:0]    status_q;
  logic [7:0]    result_q;
  logic [7:0]    drop_q;

  logic          rx_receiving;
  logic          rx_active;
  logic          frame_ok;
  logic          frame_bad;
  logic [W-1:0]  f_a, f_b, f_c, f_x0;
  logic          timed_out;
  logic          drop_event;

  // Frame intake only runs while the top FSM is idle; the assembler's own
  // IDLE/COLLECT/CHECK states sit underneath the top-level ST_IDLE.
  newton_frame_rx #(
    .W   (W),
    .HDR (HDR)
  ) u_frame_rx (
    .clk       (clk),
    .reset     (reset),
    .enable    (state_q == ST_IDLE),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .receiving (rx_receiving),
    .active    (rx_active),
    .frame_ok  (frame_ok),
    .frame_bad (frame_bad),
    .a         (f_a),
    .b         (f_b),
    .c         (f_c),
    .x0        (f_x0)
  );

  assign timed_out  = (timer_q == T_LAST);
  assign drop_event = rx_valid && !((state_q == ST_IDLE) && rx_receiving);

  always_comb begin
    state_d   = state_q;
    slv_start = 1'b0;
    slv_abort = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (frame_ok)       state_d = ST_LAUNCH;
        else if (frame_bad) state_d = ST_RESP_S;
      end
      ST_LAUNCH: begin
        slv_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // Done wins over a coincident timeout, so abort is suppressed then.
        if (slv_done) begin
          state_d = ST_RESP_S;
        end else if (timed_out) begin
          slv_abort = 1'b1;
          state_d   = ST_RESP_S;
        end
      end
      ST_RESP_S: begin
        tx_valid = 1'b1;
        tx_data  = status_q;
        if (tx_ready) state_d = ST_RESP_D;
      end
      ST_RESP_D: begin
        tx_valid = 1'b1;
        tx_data  = result_q;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      status_q <= '0;
      result_q <= '0;
      drop_q   <= '0;
      slv_a    <= '0;
      slv_b    <= '0;
      slv_c    <= '0;
      slv_x0   <= '0;
    end else begin
      state_q <= state_d;

      // Operands load on the CHECK->LAUNCH edge so they are already valid
      // while slv_start is high.
      if (state_q == ST_IDLE && frame_ok) begin
        slv_a  <= f_a;
        slv_b  <= f_b;
        slv_c  <= f_c;
        slv_x0 <= f_x0;
      end
      if (state_q == ST_IDLE && frame_bad) begin
        status_q <= STATUS_CKSUM;
        result_q <= '0;
      end

      if (state_q == ST_LAUNCH)    timer_q <= '0;
      else if (state_q == ST_WAIT) timer_q <= timer_q + TW'(1);

      if (state_q == ST_WAIT) begin
        if (slv_done) begin
          status_q <= slv_failed ? STATUS_FAIL : STATUS_OK;
          result_q <= slv_failed ? 8'h00 : 8'(slv_x);
        end else if (timed_out) begin
          status_q <= STATUS_TIMEOUT;
          result_q <= '0;
        end
      end

      if (drop_event && drop_q != '1) drop_q <= drop_q + 8'd1;
    end
  end

  assign busy     = (state_q != ST_IDLE) || rx_active;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_newton_job_sequencer.sv
// tb_newton_job_sequencer: directed self-checking bench for newton_job_sequencer.
// Expected TX bytes are queued when the solver response is driven and popped
// by a monitor whenever the DUT completes a TX handshake.
module tb_newton_job_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] slv_a, slv_b, slv_c, slv_x0;
  logic       slv_start, slv_abort;
  logic       slv_done, slv_failed;
  logic [3:0] slv_x;
  logic       busy;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  int starts = 0;
  logic [7:0] exp_q[$];

  newton_job_sequencer #(
    .W       (4),
    .TIMEOUT (16),
    .HDR     (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .slv_a      (slv_a),
    .slv_b      (slv_b),
    .slv_c      (slv_c),
    .slv_x0     (slv_x0),
    .slv_start  (slv_start),
    .slv_abort  (slv_abort),
    .slv_done   (slv_done),
    .slv_failed (slv_failed),
    .slv_x      (slv_x),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX scoreboard: compare each accepted byte with the oldest expectation.
  always @(negedge clk) begin
    if (slv_start) starts++;
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'(tx_data), 32'h100);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] x0,
                            input logic [7:0] ck);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(x0);
    send_byte(ck);
  endtask

  // Returns at the negedge of the cycle where slv_start is high.
  task automatic wait_start(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (slv_start) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // One-cycle solver completion during WAIT; queues the expected response.
  task automatic respond(input logic failed, input logic [3:0] x,
                         input logic [7:0] e_status, input logic [7:0] e_result);
    @(posedge clk); #1;
    slv_done   = 1'b1;
    slv_failed = failed;
    slv_x      = x;
    exp_q.push_back(e_status);
    exp_q.push_back(e_result);
    @(posedge clk); #1;
    slv_done   = 1'b0;
    slv_failed = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit stall_ok;
    int starts_before;

    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    slv_done = 1'b0; slv_failed = 1'b0; slv_x = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_tx_valid", 32'(tx_valid),  32'd0);
    check("rst_tx_data",  32'(tx_data),   32'd0);
    check("rst_start",    32'(slv_start), 32'd0);
    check("rst_abort",    32'(slv_abort), 32'd0);
    check("rst_slv_ops",  32'({slv_a, slv_b, slv_c, slv_x0}), 32'd0);
    check("rst_drop",     32'(drop_cnt),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: hunting byte, then good frame; start latency and operands; ok response.
    send_byte(8'h33);
    send_frame(8'h01, 8'hFE, 8'hFF, 8'h00, 8'hA5);
    @(negedge clk);
    check("t1_start_check", 32'(slv_start), 32'd0);
    @(negedge clk);
    check("t1_start_launch", 32'(slv_start), 32'd1);
    check("t1_ops", 32'({slv_a, slv_b, slv_c, slv_x0}), 32'h1EF0);
    respond(1'b0, 4'hF, 8'h00, 8'hFF);
    wait_drain("t1_drain");
    check("t1_starts", 32'(starts), 32'd1);

    // 2: same frame, solver reports failure.
    send_frame(8'h01, 8'hFE, 8'hFF, 8'h00, 8'hA5);
    wait_start("t2_start");
    respond(1'b1, 4'h7, 8'h01, 8'h00);
    wait_drain("t2_drain");

    // 3: bad checksum, no launch.
    starts_before = starts;
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h00);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    wait_drain("t3_drain");
    check("t3_no_start", 32'(starts), 32'(starts_before));

    // 4: silent solver, abort TIMEOUT cycles after start.
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hA1);
    wait_start("t4_start");
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if (slv_abort) n = i;
    end
    check("t4_abort_delay", 32'(n), 32'd16);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    @(negedge clk);
    check("t4_abort_pulse", 32'(slv_abort), 32'd0);
    wait_drain("t4_drain");
    check("t4_no_drops", 32'(drop_cnt), 32'd0);

    // 5: bytes dropped during WAIT, TX stalled during RESP_S.
    @(posedge clk); #1;
    tx_ready = 1'b0;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hA1);
    wait_start("t5_start");
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h11);
    respond(1'b0, 4'h3, 8'h00, 8'h03);
    stall_ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== 8'h00) stall_ok = 0;
    end
    check("t5_stall_hold", 32'(stall_ok), 32'd1);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd3);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain("t5_drain");

    // 6: reset mid-frame, then a clean job.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hFE);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_busy_after_reset", 32'(busy), 32'd0);
    check("t6_drop_cleared", 32'(drop_cnt), 32'd0);
    starts_before = starts;
    send_frame(8'h01, 8'hFE, 8'hFF, 8'h00, 8'hA5);
    wait_start("t6_start");
    respond(1'b0, 4'h5, 8'h00, 8'h05);
    wait_drain("t6_drain");
    check("t6_one_start", 32'(starts), 32'(starts_before + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
